// File: rtl/uart_prog_loader.sv
// UART (8N1) program loader: assembles little-endian 32-bit words from received
// bytes and writes them to instruction memory until full or an end marker arrives.
module uart_prog_loader #(
  parameter int CLKS_PER_BIT = 347,
  parameter int NUM_WORDS    = 256,
  parameter int ADDR_W       = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rx_i,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [31:0]       mem_wdata_o,
  output logic              prog_done_o,
  output logic              frame_err_o,
  output logic [1:0]        dbg_state_o
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam int WC_W  = $clog2(NUM_WORDS + 1);
  localparam logic [CNT_W-1:0] HALF_CNT = CNT_W'(CLKS_PER_BIT / 2);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [WC_W-1:0]  NUM_WC   = WC_W'(NUM_WORDS);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t            state_q, state_d;
  logic              rx_meta_q, rx_sync_q, rx_prev_q;
  logic [CNT_W-1:0]  clk_cnt_q, clk_cnt_d;
  logic [2:0]        bit_cnt_q, bit_cnt_d;
  logic [7:0]        shift_q, shift_d;
  logic [1:0]        byte_pos_q, byte_pos_d;
  logic [23:0]       word_q, word_d;
  logic [WC_W-1:0]   word_cnt_q, word_cnt_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic              done_q, done_d;
  logic              ferr_q, ferr_d;
  logic [31:0]       full_word;

  // The fourth byte completes the word straight from the shift register.
  assign full_word = {shift_q, word_q};

  always_comb begin
    state_d    = state_q;
    clk_cnt_d  = clk_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    byte_pos_d = byte_pos_q;
    word_d     = word_q;
    word_cnt_d = word_cnt_q;
    we_d       = 1'b0;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    done_d     = done_q;
    ferr_d     = ferr_q;

    // The count has already advanced past the last slot while the final strobe is high.
    if (we_q && (word_cnt_q == NUM_WC)) done_d = 1'b1;

    case (state_q)
      IDLE: begin
        clk_cnt_d = '0;
        bit_cnt_d = '0;
        if (!done_q && rx_prev_q && !rx_sync_q) state_d = START;
      end
      START: begin
        if (clk_cnt_q == HALF_CNT) begin
          clk_cnt_d = '0;
          state_d   = rx_sync_q ? IDLE : DATA;
        end else begin
          clk_cnt_d = clk_cnt_q + CNT_W'(1);
        end
      end
      DATA: begin
        if (clk_cnt_q == LAST_CNT) begin
          clk_cnt_d = '0;
          shift_d   = {rx_sync_q, shift_q[7:1]};
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) state_d = STOP;
        end else begin
          clk_cnt_d = clk_cnt_q + CNT_W'(1);
        end
      end
      STOP: begin
        if (clk_cnt_q == LAST_CNT) begin
          clk_cnt_d = '0;
          state_d   = IDLE;
          if (!done_q) begin
            if (!rx_sync_q) begin
              ferr_d = 1'b1;
            end else if (byte_pos_q == 2'd3) begin
              byte_pos_d = '0;
              word_d     = '0;
              if (full_word == 32'hFFFF_FFFF) begin
                done_d = 1'b1;
              end else begin
                we_d       = 1'b1;
                addr_d     = ADDR_W'(word_cnt_q);
                wdata_d    = full_word;
                word_cnt_d = word_cnt_q + WC_W'(1);
              end
            end else begin
              case (byte_pos_q)
                2'd0:    word_d[7:0]   = shift_q;
                2'd1:    word_d[15:8]  = shift_q;
                default: word_d[23:16] = shift_q;
              endcase
              byte_pos_d = byte_pos_q + 2'd1;
            end
          end
        end else begin
          clk_cnt_d = clk_cnt_q + CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      rx_meta_q  <= 1'b1;
      rx_sync_q  <= 1'b1;
      rx_prev_q  <= 1'b1;
      clk_cnt_q  <= '0;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      byte_pos_q <= '0;
      word_q     <= '0;
      word_cnt_q <= '0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      done_q     <= 1'b0;
      ferr_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      rx_meta_q  <= rx_i;
      rx_sync_q  <= rx_meta_q;
      rx_prev_q  <= rx_sync_q;
      clk_cnt_q  <= clk_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      byte_pos_q <= byte_pos_d;
      word_q     <= word_d;
      word_cnt_q <= word_cnt_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      done_q     <= done_d;
      ferr_q     <= ferr_d;
    end
  end

  assign mem_we_o    = we_q;
  assign mem_addr_o  = addr_q;
  assign mem_wdata_o = wdata_q;
  assign prog_done_o = done_q;
  assign frame_err_o = ferr_q;
  assign dbg_state_o = state_q;

endmodule

// File: doc/uart_prog_loader.md
UART_PROG_LOADER -- requirements
Module: uart_prog_loader

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 347, meaning clock cycles per UART bit (40 MHz / 115200 baud); legal range is 4 or more.
REQ-002 SHALL have parameter NUM_WORDS, default 256, meaning the maximum number of 32-bit words loaded.
REQ-003 SHALL have parameter ADDR_W, default 8, meaning the word-address width; it SHALL satisfy 2**ADDR_W >= NUM_WORDS.
REQ-004 SHALL have port clk, input, 1 bit: the single clock.
REQ-005 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-006 SHALL have port rx_i, input, 1 bit: asynchronous UART serial line, idle high.
REQ-007 SHALL have port mem_we_o, output, 1 bit: one-cycle instruction-memory write strobe.
REQ-008 SHALL have port mem_addr_o, output, ADDR_W bits: word address of the write.
REQ-009 SHALL have port mem_wdata_o, output, 32 bits: write data.
REQ-010 SHALL have port prog_done_o, output, 1 bit: load complete; drives the project-ready pin.
REQ-011 SHALL have port frame_err_o, output, 1 bit: sticky flag, set on a framing error.

Function
REQ-012 SHALL pass rx_i through a two-flop synchronizer; all decoding SHALL use the synchronized value.
REQ-013 SHALL decode the line as 8N1, LSB first.
REQ-014 Receiver FSM SHALL have states IDLE, START, DATA, STOP, with transitions:
- IDLE->START on a synchronized high-to-low transition.
- START->DATA if the line is low at count CLKS_PER_BIT/2 (integer division); otherwise START->IDLE (glitch).
- DATA: sample one bit every CLKS_PER_BIT cycles after the mid-start sample; DATA->STOP after the 8th bit.
- STOP: sample CLKS_PER_BIT cycles after the 8th data bit, then return to IDLE.
REQ-015 In STOP, a high sample SHALL accept the byte; a low sample SHALL discard the byte and set frame_err_o.
REQ-016 SHALL assemble accepted bytes little-endian: the first byte goes to bits [7:0], the fourth byte to bits [31:24].
REQ-017 On the fourth accepted byte of a word:
- If the word equals 32'hFFFF_FFFF (end marker), it SHALL NOT be written and prog_done_o SHALL set on the next cycle.
- Otherwise SHALL assert mem_we_o for exactly one cycle, with mem_wdata_o = word and mem_addr_o = current word count.
REQ-018 The word count SHALL start at 0 and SHALL increment by 1 after each write.
REQ-019 prog_done_o SHALL set in the cycle after the NUM_WORDS-th write, or per REQ-017 on the end marker.
REQ-020 Once prog_done_o is high, it SHALL stay high until reset; all further rx_i activity SHALL be ignored (no writes, no flag changes).
REQ-021 Write latency SHALL be: mem_we_o asserts 1 cycle after the stop-bit sample of the fourth byte.
REQ-022 mem_addr_o and mem_wdata_o SHALL hold their last values when mem_we_o is low.
REQ-023 A framing error SHALL NOT reset the byte position or the word count; the next valid byte fills the same slot.
REQ-024 A new start edge arriving during STOP SHALL be recognised only after returning to IDLE; back-to-back frames with a single stop bit SHALL be received without loss.
REQ-025 Counters SHALL be sized so they cannot wrap: bit counter 0..7, byte position 0..3, word count 0..NUM_WORDS.

Reset
REQ-026 Asserting rst_n low SHALL immediately force, asynchronously:
- FSM to IDLE; all counters and the partial word to 0.
- mem_we_o = 0, mem_addr_o = 0, mem_wdata_o = 0, prog_done_o = 0, frame_err_o = 0.
- Synchronizer flops to 1.
REQ-027 Reset asserted mid-byte or mid-word SHALL discard all partial data; after release, the next start bit begins byte 0 of word 0.

Verification (CLKS_PER_BIT=4, NUM_WORDS=4)
REQ-028 Bytes 13,00,00,00 then 93,02,10,00 -> writes (addr 0, data 32'h0000_0013), (addr 1, data 32'h0010_0293); each mem_we_o pulse is 1 cycle wide; prog_done_o = 0.
REQ-029 Four words 11111111..44444444 -> four writes at addr 0..3; prog_done_o = 1 one cycle after the 4th write; a fifth word is ignored.
REQ-030 Word AABBCCDD then FF,FF,FF,FF -> one write (addr 0); prog_done_o = 1; no write for the marker.
REQ-031 Byte 55 with stop bit low, then 01,02,03,04 -> frame_err_o = 1; write addr 0, data 32'h0403_0201.
REQ-032 Low pulse of 1 cycle on rx_i -> no byte accepted; FSM back in IDLE; no flags set.
REQ-033 rst_n low after 2 bytes of a word, then release and send 01,02,03,04 -> write addr 0, data 32'h0403_0201; frame_err_o = 0.
